// File: rtl/alpha_blend_multi.sv
// -----------------------------------------------------------------------------
// alpha_blend_multi
//
// Composites NUM_LAYERS layer buffers, bottom (layer 0) to top (layer
// NUM_LAYERS-1), one DATA_SIZE_WORDS-pixel block at a time, and writes each
// blended block to a destination buffer through a ready-handshaked SRAM port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   blend_en          start request (honoured only in IDLE / DONE)
//   mode              0 alpha, 1 add-saturate, 2 multiply, 3 colour-key
//   alpha_values      slice k = alpha of layer k (slice 0 unused)
//   dest_base         destination buffer base pixel address
//   busy, blend_done  status
//   read_enable,
//   write_enable,
//   address           SRAM request; held until mem_ready
//   mem_ready         SRAM acknowledge, read_data valid in the same cycle
//   read_data         block read from SRAM
//   write_data        accumulator register, stable throughout a write request
// -----------------------------------------------------------------------------
module alpha_blend_multi #(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64,
  parameter int NUM_LAYERS      = 2,
  parameter int ALPHA_BITS      = 8,
  parameter int LAYER_WORDS     = 65536
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    blend_en,
  input  logic [1:0]                              mode,
  input  logic [NUM_LAYERS*ALPHA_BITS-1:0]        alpha_values,
  input  logic [ADDR_SIZE_BITS-1:0]               dest_base,
  output logic                                    busy,
  output logic                                    blend_done,
  output logic                                    read_enable,
  output logic                                    write_enable,
  output logic [ADDR_SIZE_BITS-1:0]               address,
  input  logic                                    mem_ready,
  input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
  output logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] write_data
);

  localparam int PIX_W = WORD_SIZE_BYTES * 8;
  localparam int BLK_W = PIX_W * DATA_SIZE_WORDS;
  localparam int AW    = ADDR_SIZE_BITS;
  localparam int MIX_W = 8 + ALPHA_BITS + 1;

  localparam logic [AW-1:0] LAYER_STRIDE = AW'(LAYER_WORDS);
  localparam logic [AW-1:0] BLOCK_STEP   = AW'(DATA_SIZE_WORDS);
  localparam logic [AW-1:0] LAST_OFFSET  = AW'(LAYER_WORDS - DATA_SIZE_WORDS);
  localparam logic [1:0]    K_LAST       = 2'(NUM_LAYERS - 1);
  localparam logic [ALPHA_BITS:0] ALPHA_ONE = {1'b1, {ALPHA_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_BLEND, S_WR_REQ, S_UPDATE, S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [AW-1:0]                   offset_q, offset_d;
  logic [1:0]                      k_q, k_d;
  logic [BLK_W-1:0]                acc_q, acc_d;
  logic [BLK_W-1:0]                top_q, top_d;
  logic [1:0]                      mode_q, mode_d;
  logic [NUM_LAYERS*ALPHA_BITS-1:0] alpha_q, alpha_d;
  logic [AW-1:0]                   dest_q, dest_d;

  logic [BLK_W-1:0]                blend_res;
  logic [ALPHA_BITS-1:0]           alpha_k;

  // All-ones alpha is promoted to 2^ALPHA_BITS so the top layer comes through
  // exactly instead of being attenuated by one LSB.
  function automatic logic [7:0] alpha_mix(input logic [7:0] t, input logic [7:0] a,
                                           input logic [ALPHA_BITS-1:0] al);
    logic [ALPHA_BITS:0] a_eff;
    logic [MIX_W-1:0]    sum;
    a_eff = (&al) ? ALPHA_ONE : {1'b0, al};
    sum   = MIX_W'(t) * MIX_W'(a_eff) + MIX_W'(a) * MIX_W'(ALPHA_ONE - a_eff);
    return 8'(sum >> ALPHA_BITS);
  endfunction

  function automatic logic [7:0] add_sat(input logic [7:0] t, input logic [7:0] a);
    logic [8:0] s;
    s = {1'b0, t} + {1'b0, a};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] mul8(input logic [7:0] t, input logic [7:0] a);
    logic [15:0] p;
    p = 16'(t) * 16'(a);
    return 8'(p >> 8);
  endfunction

  // Blend of the captured top block over the accumulator for layer k_q.
  always_comb begin
    logic [PIX_W-1:0] top_pix;
    logic             keep_acc;
    logic [7:0]       t_byte, a_byte, r_byte;
    blend_res = acc_q;
    alpha_k   = alpha_q[k_q*ALPHA_BITS +: ALPHA_BITS];
    top_pix   = '0;
    keep_acc  = 1'b0;
    t_byte    = '0;
    a_byte    = '0;
    r_byte    = '0;
    for (int p = 0; p < DATA_SIZE_WORDS; p++) begin
      top_pix  = top_q[p*PIX_W +: PIX_W];
      // Colour-key: an all-zero top pixel is transparent.
      keep_acc = (mode_q == 2'd3) && (top_pix == '0);
      for (int b = 0; b < WORD_SIZE_BYTES; b++) begin
        t_byte = top_q[p*PIX_W + b*8 +: 8];
        a_byte = acc_q[p*PIX_W + b*8 +: 8];
        case (mode_q)
          2'd1:    r_byte = add_sat(t_byte, a_byte);
          2'd2:    r_byte = mul8(t_byte, a_byte);
          default: r_byte = alpha_mix(t_byte, a_byte, alpha_k);
        endcase
        blend_res[p*PIX_W + b*8 +: 8] = keep_acc ? a_byte : r_byte;
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    offset_d = offset_q;
    k_d      = k_q;
    acc_d    = acc_q;
    top_d    = top_q;
    mode_d   = mode_q;
    alpha_d  = alpha_q;
    dest_d   = dest_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (blend_en) begin
          mode_d   = mode;
          alpha_d  = alpha_values;
          dest_d   = dest_base;
          offset_d = '0;
          k_d      = 2'd0;
          state_d  = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (mem_ready) begin
          if (k_q == 2'd0) begin
            // Bottom layer seeds the accumulator; no blend needed.
            acc_d = read_data;
            k_d   = 2'd1;
          end else begin
            top_d   = read_data;
            state_d = S_BLEND;
          end
        end
      end
      S_BLEND: begin
        acc_d = blend_res;
        if (k_q == K_LAST) begin
          state_d = S_WR_REQ;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (mem_ready) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        k_d = 2'd0;
        if (offset_q == LAST_OFFSET) begin
          state_d = S_DONE;
        end else begin
          offset_d = offset_q + BLOCK_STEP;
          state_d  = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      k_q      <= 2'd0;
      // NOTE: the block registers are reset as well, because write_data is
      // the accumulator and must read 0 while in reset.
      acc_q    <= '0;
      top_q    <= '0;
      mode_q   <= 2'd0;
      alpha_q  <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      top_q    <= top_d;
      mode_q   <= mode_d;
      alpha_q  <= alpha_d;
      dest_q   <= dest_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them
  // without waiting for a clock edge.
  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    blend_done   = (state_q == S_DONE);
    read_enable  = (state_q == S_RD_REQ);
    write_enable = (state_q == S_WR_REQ);
    write_data   = acc_q;
    case (state_q)
      S_RD_REQ: address = AW'(k_q) * LAYER_STRIDE + offset_q;
      S_WR_REQ: address = dest_q + offset_q;
      default:  address = '0;
    endcase
  end

endmodule

// File: tb/tb_alpha_blend_multi.sv
// -----------------------------------------------------------------------------
// tb_alpha_blend_multi
//
// Two instances share one SRAM model: a 2-layer and a 3-layer blender, both
// with 128-pixel layers and 64-pixel blocks. A negedge process plays the SRAM
// (random stalls, read data) and checks every accepted request against an
// expected request queue and every written block against a per-pixel model.
// -----------------------------------------------------------------------------
module tb_alpha_blend_multi;

  localparam int LW    = 128;
  localparam int DSW   = 64;
  localparam int BLK_W = 3 * DSW * 8;

  typedef struct {
    logic        we;
    logic [23:0] addr;
  } req_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en2, en3;
  logic [1:0]        mode;
  logic [15:0]       alpha2;
  logic [23:0]       alpha3;
  logic [23:0]       dest_base;
  logic              mem_ready;
  logic [BLK_W-1:0]  read_data;

  logic              busy2, done2, re2, we2, busy3, done3, re3, we3;
  logic [23:0]       addr2, addr3;
  logic [BLK_W-1:0]  wd2, wd3;

  logic              sel;
  logic              m_busy, m_done, m_re, m_we;
  logic [23:0]       m_addr;
  logic [BLK_W-1:0]  m_wd;

  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  int                nl;
  int                alpha_arr [0:3];
  int                stall_pct;
  logic [23:0]       layer_pix [0:3][0:LW-1];
  logic [23:0]       wr_buf    [0:LW-1];
  req_t              exp_q [$];
  int                wr_cyc [$];

  alpha_blend_multi #(.ADDR_SIZE_BITS(24), .WORD_SIZE_BYTES(3), .DATA_SIZE_WORDS(DSW),
                      .NUM_LAYERS(2), .ALPHA_BITS(8), .LAYER_WORDS(LW)) dut2 (
    .clk(clk), .rst(rst), .blend_en(en2), .mode(mode), .alpha_values(alpha2),
    .dest_base(dest_base), .busy(busy2), .blend_done(done2), .read_enable(re2),
    .write_enable(we2), .address(addr2), .mem_ready(mem_ready),
    .read_data(read_data), .write_data(wd2));

  alpha_blend_multi #(.ADDR_SIZE_BITS(24), .WORD_SIZE_BYTES(3), .DATA_SIZE_WORDS(DSW),
                      .NUM_LAYERS(3), .ALPHA_BITS(8), .LAYER_WORDS(LW)) dut3 (
    .clk(clk), .rst(rst), .blend_en(en3), .mode(mode), .alpha_values(alpha3),
    .dest_base(dest_base), .busy(busy3), .blend_done(done3), .read_enable(re3),
    .write_enable(we3), .address(addr3), .mem_ready(mem_ready),
    .read_data(read_data), .write_data(wd3));

  assign m_busy = sel ? busy3 : busy2;
  assign m_done = sel ? done3 : done2;
  assign m_re   = sel ? re3   : re2;
  assign m_we   = sel ? we3   : we2;
  assign m_addr = sel ? addr3 : addr2;
  assign m_wd   = sel ? wd3   : wd2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-pixel reference: plain integer arithmetic on the blend rules.
  function automatic logic [23:0] blend_pix(input int md, input logic [23:0] top,
                                            input logic [23:0] acc, input int al);
    logic [23:0] res;
    int t, a, r, ae;
    if (md == 3 && top == 24'h0) return acc;
    res = '0;
    ae  = (al == 255) ? 256 : al;
    for (int b = 0; b < 3; b++) begin
      t = int'(top[b*8 +: 8]);
      a = int'(acc[b*8 +: 8]);
      case (md)
        1:       r = (t + a > 255) ? 255 : t + a;
        2:       r = (t * a) / 256;
        default: r = (t * ae + a * (256 - ae)) / 256;
      endcase
      res[b*8 +: 8] = 8'(r);
    end
    return res;
  endfunction

  function automatic logic [23:0] model_pix(input int o);
    logic [23:0] acc;
    acc = layer_pix[0][o];
    for (int k = 1; k < nl; k++) acc = blend_pix(int'(mode), layer_pix[k][o], acc, alpha_arr[k]);
    return acc;
  endfunction

  function automatic logic [BLK_W-1:0] rd_block(input logic [23:0] a);
    logic [BLK_W-1:0] r;
    int ly, o;
    r  = '0;
    ly = int'(a) / LW;
    o  = int'(a) % LW;
    for (int i = 0; i < DSW; i++)
      if (ly < 4 && o + i < LW) r[i*24 +: 24] = layer_pix[ly][o + i];
    return r;
  endfunction

  // SRAM model and compare process.
  initial begin
    logic        prev_pend;
    logic        prev_re, prev_we, ready;
    logic [23:0] prev_addr;
    req_t        e;
    int          off, bad;
    logic [23:0] gp, ep;
    prev_pend = 1'b0;
    prev_re = 1'b0; prev_we = 1'b0; prev_addr = '0;
    mem_ready = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ready = 1'b0;
        prev_pend = 1'b0;
        continue;
      end
      if (prev_pend) check("hold_during_stall", {m_re, m_we, m_addr}, {prev_re, prev_we, prev_addr});
      ready     = ($urandom_range(99) >= stall_pct);
      mem_ready = ready;
      read_data = rd_block(m_addr);
      if (m_re || m_we) begin
        check("enables_exclusive", 64'(m_re & m_we), 64'd0);
        check("busy_during_req", 64'(m_busy), 64'd1);
        if (ready) begin
          prev_pend = 1'b0;
          check("req_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_kind", 64'(m_we), 64'(e.we));
            check("req_addr", 64'(m_addr), 64'(e.addr));
            if (m_we) begin
              wr_cyc.push_back(cyc);
              off = int'(m_addr - dest_base);
              bad = -1;
              for (int i = 0; i < DSW; i++) begin
                gp = m_wd[i*24 +: 24];
                if (off + i < LW) begin
                  wr_buf[off + i] = gp;
                  if (bad < 0 && gp !== model_pix(off + i)) bad = i;
                end
              end
              if (bad < 0) bad = 0;
              gp = m_wd[bad*24 +: 24];
              ep = (off + bad < LW) ? model_pix(off + bad) : 24'h0;
              check($sformatf("wr_data_pix%0d", off + bad), 64'(gp), 64'(ep));
            end
          end
        end else begin
          prev_pend = 1'b1;
          prev_re   = m_re;
          prev_we   = m_we;
          prev_addr = m_addr;
        end
      end else begin
        prev_pend = 1'b0;
      end
    end
  end

  task automatic fill_random();
    for (int k = 0; k < 4; k++)
      for (int o = 0; o < LW; o++) layer_pix[k][o] = 24'($urandom);
  endtask

  task automatic fill_uniform(input int k, input logic [23:0] v);
    for (int o = 0; o < LW; o++) layer_pix[k][o] = v;
  endtask

  task automatic start_run(input logic which, input logic [1:0] md, input int a1,
                           input int a2, input int stall, input logic [23:0] dst);
    sel          = which;
    nl           = which ? 3 : 2;
    mode         = md;
    alpha_arr[1] = a1;
    alpha_arr[2] = a2;
    alpha2       = {8'(a1), 8'h00};
    alpha3       = {8'(a2), 8'(a1), 8'h00};
    dest_base    = dst;
    stall_pct    = stall;
    exp_q.delete();
    wr_cyc.delete();
    for (int blk = 0; blk < LW / DSW; blk++) begin
      for (int k = 0; k < nl; k++) exp_q.push_back('{1'b0, 24'(k * LW + blk * DSW)});
      exp_q.push_back('{1'b1, dst + 24'(blk * DSW)});
    end
    @(negedge clk);
    if (which) en3 = 1'b1; else en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    en3 = 1'b0;
    check("started_busy", 64'(m_busy), 64'd1);
  endtask

  task automatic finish_run(input logic pulse_busy);
    int t;
    t = 0;
    while (!m_done && t < 2000) begin
      @(negedge clk);
      t++;
      if (pulse_busy && t == 6) begin
        if (sel) en3 = 1'b1; else en2 = 1'b1;
      end else begin
        en2 = 1'b0;
        en3 = 1'b0;
      end
    end
    en2 = 1'b0;
    en3 = 1'b0;
    check("done_reached", 64'(m_done), 64'd1);
    check("all_reqs_seen", 64'(exp_q.size()), 64'd0);
    if (stall_pct == 0 && wr_cyc.size() == 2)
      check("cycles_per_block", 64'(wr_cyc[1] - wr_cyc[0]), 64'(2 * nl + 1));
  endtask

  initial begin
    int t;
    rst = 1'b1; en2 = 1'b0; en3 = 1'b0; mode = 2'd0; alpha2 = '0; alpha3 = '0;
    dest_base = '0; sel = 1'b0; nl = 2; stall_pct = 0;
    for (int k = 0; k < 4; k++) alpha_arr[k] = 0;
    for (int o = 0; o < LW; o++) wr_buf[o] = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'({busy2, busy3}), 64'd0);
    check("rst_done", 64'({done2, done3}), 64'd0);
    check("rst_enables", 64'({re2, we2, re3, we3}), 64'd0);
    check("rst_address", 64'({addr2, addr3}), 64'd0);
    check("rst_write_data", 64'(|{wd2, wd3}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, alpha 128: 100/200 mix gives 150; ready tied high.
    fill_uniform(0, 24'h646464);
    fill_uniform(1, 24'hC8C8C8);
    start_run(1'b0, 2'd0, 128, 0, 0, 24'h001000);
    finish_run(1'b0);
    check("m0_a128_pix0", 64'(wr_buf[0]), 64'h969696);
    check("m0_a128_pix127", 64'(wr_buf[127]), 64'h969696);

    // Alpha max passes the top layer through exactly.
    fill_random();
    layer_pix[1][0] = 24'h123456;
    start_run(1'b0, 2'd0, 255, 0, 25, 24'h002000);
    finish_run(1'b0);
    check("m0_a255_literal", 64'(wr_buf[0]), 64'h123456);
    check("m0_a255_pix77", 64'(wr_buf[77]), 64'(layer_pix[1][77]));

    // Alpha 0 keeps the bottom layer exactly.
    fill_random();
    layer_pix[0][0] = 24'hABCDEF;
    start_run(1'b0, 2'd0, 0, 0, 0, 24'h002000);
    finish_run(1'b0);
    check("m0_a0_literal", 64'(wr_buf[0]), 64'hABCDEF);
    check("m0_a0_pix100", 64'(wr_buf[100]), 64'(layer_pix[0][100]));

    // Add-saturate: 200 over 100 clips to 255.
    fill_uniform(0, 24'h646464);
    fill_uniform(1, 24'hC8C8C8);
    start_run(1'b0, 2'd1, 17, 0, 30, 24'h003000);
    finish_run(1'b0);
    check("m1_sat", 64'(wr_buf[5]), 64'hFFFFFF);

    // Multiply: 255*255 -> 254, 128 over 200 -> 100.
    fill_random();
    layer_pix[0][0] = 24'hFFFFFF; layer_pix[1][0] = 24'hFFFFFF;
    layer_pix[0][1] = 24'hC8C8C8; layer_pix[1][1] = 24'h808080;
    start_run(1'b0, 2'd2, 200, 0, 0, 24'h003000);
    finish_run(1'b0);
    check("m2_255x255", 64'(wr_buf[0]), 64'hFEFEFE);
    check("m2_128x200", 64'(wr_buf[1]), 64'h646464);

    // Colour-key: zero top pixel is transparent, others blend at alpha.
    fill_random();
    layer_pix[1][0] = 24'h000000; layer_pix[0][0] = 24'h0A0B0C;
    layer_pix[1][1] = 24'h010000;
    layer_pix[1][70] = 24'h000000;
    start_run(1'b0, 2'd3, 255, 0, 20, 24'h004000);
    finish_run(1'b0);
    check("m3_key_keep", 64'(wr_buf[0]), 64'h0A0B0C);
    check("m3_key_blend", 64'(wr_buf[1]), 64'h010000);
    fill_random();
    layer_pix[1][3] = 24'h000000;
    start_run(1'b0, 2'd3, 100, 0, 0, 24'h004000);
    finish_run(1'b0);

    // Three layers, stalls, and a start pulse while busy that must be ignored.
    // 100,200 at alpha 64 -> 125; then 0 over 125 at alpha 192 -> 31.
    fill_uniform(0, 24'h646464);
    fill_uniform(1, 24'hC8C8C8);
    fill_uniform(2, 24'h000000);
    start_run(1'b1, 2'd0, 64, 192, 40, 24'h030000);
    finish_run(1'b1);
    check("nl3_literal", 64'(wr_buf[64]), 64'h1F1F1F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_holds", 64'({m_done, m_busy}), 64'b10);
    end

    // Random data through three layers, ready tied high.
    fill_random();
    start_run(1'b1, 2'd0, 77, 230, 0, 24'h030000);
    finish_run(1'b0);

    // Reset during the second block's first read.
    fill_random();
    start_run(1'b1, 2'd0, 90, 160, 0, 24'h030000);
    t = 0;
    while (!(m_re && m_addr == 24'h000040) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reached_blk1_read", 64'(m_re && m_addr == 24'h000040), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'({m_busy, m_done}), 64'd0);
    check("async_rst_enables", 64'({m_re, m_we}), 64'd0);
    check("async_rst_address", 64'(m_addr), 64'd0);
    check("async_rst_wd", 64'(|m_wd), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'({m_busy, m_done, m_re, m_we}), 64'd0);
    start_run(1'b1, 2'd1, 0, 0, 15, 24'h030000);
    finish_run(1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
